sram_access_arbiter: RTL and testbench

//  Shares the single-port data SRAM between three requesters: 0 = CPU load/store path, 1 = stack engine,
//  2 = external loader/debug port. Each requester gets a req/ack handshake.
//  The arbiter grants one requester at a time and latches its command. It then drives the SRAM

---
 rtl/sram_access_arbiter.sv | 165 ++++++++++++++++
 tb/tb_sram_access_arbiter.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_access_arbiter.sv
// Three-requester round-robin arbiter for the single-port data SRAM.
// Optional build macro SRAM_ARB_CPU_PRIO_EN: requester 0 (CPU) gets fixed priority over 1 and 2.
module sram_access_arbiter #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 8,
  parameter int WAIT_CYC = 1   // legal range 1..15
) (
  input  logic                  clk,
  input  logic                  Reset,
  input  logic [2:0]            req,
  input  logic [2:0]            we,
  input  logic [3*ADDR_W-1:0]   addr,
  input  logic [3*DATA_W-1:0]   wdata,
  output logic [2:0]            gnt,
  output logic [2:0]            ack,
  output logic [DATA_W-1:0]     rdata,
  output logic [ADDR_W-1:0]     SRAMAddress,
  output logic [DATA_W-1:0]     SRAMDatain,
  output logic                  SRAMRead,
  output logic                  SRAMWrite,
  input  logic [DATA_W-1:0]     SRAMDataout
);

  localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t              r_state;
  logic [3:0]          r_cnt;
  logic [1:0]          r_last;
  logic                r_we;
  logic [2:0]          r_gnt;
  logic [2:0]          r_ack;
  logic [DATA_W-1:0]   r_rdata;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_din;
  logic                r_rd;
  logic                r_wr;

  logic                w_win_vld;
  logic [1:0]          w_win_idx;
  logic                w_upd_last;
  logic [ADDR_W-1:0]   w_win_addr;
  logic [DATA_W-1:0]   w_win_data;
  logic                w_win_we;

  function automatic logic [1:0] f_next(input logic [1:0] idx);
    return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
  endfunction

`ifdef SRAM_ARB_CPU_PRIO_EN
  logic [1:0] w_first;
  logic [1:0] w_second;

  // CPU wins outright; 1 and 2 rotate using the pointer, which CPU grants leave untouched.
  always_comb begin
    w_win_vld  = 1'b0;
    w_win_idx  = 2'd0;
    w_upd_last = 1'b0;
    w_first    = (r_last == 2'd1) ? 2'd2 : 2'd1;
    w_second   = (r_last == 2'd1) ? 2'd1 : 2'd2;
    if (req[0]) begin
      w_win_vld = 1'b1;
      w_win_idx = 2'd0;
    end else if (req[w_first]) begin
      w_win_vld  = 1'b1;
      w_win_idx  = w_first;
      w_upd_last = 1'b1;
    end else if (req[w_second]) begin
      w_win_vld  = 1'b1;
      w_win_idx  = w_second;
      w_upd_last = 1'b1;
    end
  end
`else
  logic [1:0] w_c1;
  logic [1:0] w_c2;

  // Search order starts just after the last winner, so the last winner is checked last.
  always_comb begin
    w_win_vld  = 1'b0;
    w_win_idx  = 2'd0;
    w_upd_last = 1'b1;
    w_c1       = f_next(r_last);
    w_c2       = f_next(w_c1);
    if (req[w_c1]) begin
      w_win_vld = 1'b1;
      w_win_idx = w_c1;
    end else if (req[w_c2]) begin
      w_win_vld = 1'b1;
      w_win_idx = w_c2;
    end else if (req[r_last]) begin
      w_win_vld = 1'b1;
      w_win_idx = r_last;
    end
  end
`endif

  assign w_win_addr = addr[w_win_idx*ADDR_W +: ADDR_W];
  assign w_win_data = wdata[w_win_idx*DATA_W +: DATA_W];
  assign w_win_we   = we[w_win_idx];

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_last  <= 2'd2;
      r_we    <= 1'b0;
      r_gnt   <= 3'b000;
      r_ack   <= 3'b000;
      r_rdata <= '0;
      r_addr  <= '0;
      r_din   <= '0;
      r_rd    <= 1'b0;
      r_wr    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_win_vld) begin
            r_gnt   <= 3'b001 << w_win_idx;
            if (w_upd_last) r_last <= w_win_idx;
            r_addr  <= w_win_addr;
            r_din   <= w_win_data;
            r_we    <= w_win_we;
            r_rd    <= ~w_win_we;
            r_wr    <= w_win_we;
            r_cnt   <= CNT_LOAD;
            r_state <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end else begin
            // Last strobe cycle: SRAM output is valid now, so sample it on the way out.
            r_rd    <= 1'b0;
            r_wr    <= 1'b0;
            if (!r_we) r_rdata <= SRAMDataout;
            r_ack   <= r_gnt;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_ack   <= 3'b000;
          r_gnt   <= 3'b000;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign gnt         = r_gnt;
  assign ack         = r_ack;
  assign rdata       = r_rdata;
  assign SRAMAddress = r_addr;
  assign SRAMDatain  = r_din;
  assign SRAMRead    = r_rd;
  assign SRAMWrite   = r_wr;

endmodule

// File: tb/tb_sram_access_arbiter.sv
// Directed bench for sram_access_arbiter: dut_a uses WAIT_CYC=1, dut_b uses WAIT_CYC=4.
module tb_sram_access_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] mem [256];

  logic        rst_n_a, rst_n_b;
  logic [2:0]  req_a, we_a, req_b, we_b;
  logic [23:0] addr_a, wdata_a, addr_b, wdata_b;
  logic [2:0]  gnt_a, ack_a, gnt_b, ack_b;
  logic [7:0]  rdata_a, ao_a, di_a, dout_a;
  logic [7:0]  rdata_b, ao_b, di_b, dout_b;
  logic        rd_a, wr_a, rd_b, wr_b;

  assign dout_a = rd_a ? mem[ao_a] : 8'h00;
  assign dout_b = rd_b ? mem[ao_b] : 8'h00;

  sram_access_arbiter #(.ADDR_W(8), .DATA_W(8), .WAIT_CYC(1)) dut_a (
    .clk(clk), .Reset(rst_n_a), .req(req_a), .we(we_a), .addr(addr_a), .wdata(wdata_a),
    .gnt(gnt_a), .ack(ack_a), .rdata(rdata_a), .SRAMAddress(ao_a), .SRAMDatain(di_a),
    .SRAMRead(rd_a), .SRAMWrite(wr_a), .SRAMDataout(dout_a)
  );

  sram_access_arbiter #(.ADDR_W(8), .DATA_W(8), .WAIT_CYC(4)) dut_b (
    .clk(clk), .Reset(rst_n_b), .req(req_b), .we(we_b), .addr(addr_b), .wdata(wdata_b),
    .gnt(gnt_b), .ack(ack_b), .rdata(rdata_b), .SRAMAddress(ao_b), .SRAMDatain(di_b),
    .SRAMRead(rd_b), .SRAMWrite(wr_b), .SRAMDataout(dout_b)
  );

  task automatic test_reset();
    rst_n_a = 1'b0; rst_n_b = 1'b0;
    req_a = 3'b111; we_a = 3'b000; addr_a = '0; wdata_a = '0;
    req_b = 3'b000; we_b = 3'b000; addr_b = '0; wdata_b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if ({gnt_a, ack_a, rd_a, wr_a} !== 8'h00) begin
      n_fail++; $display("FAIL reset_ctrl_a: got %b expected 00000000", {gnt_a, ack_a, rd_a, wr_a});
    end
    n_tests++;
    if ({rdata_a, ao_a, di_a} !== 24'h0) begin
      n_fail++; $display("FAIL reset_data_a: got %h expected 000000", {rdata_a, ao_a, di_a});
    end
    n_tests++;
    if ({gnt_b, ack_b, rd_b, wr_b, rdata_b, ao_b, di_b} !== 32'h0) begin
      n_fail++; $display("FAIL reset_b: got %h expected 00000000", {gnt_b, ack_b, rd_b, wr_b, rdata_b, ao_b, di_b});
    end
    @(posedge clk); #1;
    rst_n_a = 1'b1; rst_n_b = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_tests++;
    if ({gnt_a, rd_a, wr_a} !== 5'b00110) begin
      n_fail++; $display("FAIL reset_release_gnt: got gnt=%b rd=%b wr=%b expected gnt=001 rd=1 wr=0", gnt_a, rd_a, wr_a);
    end
    req_a = 3'b000;
    repeat (4) @(posedge clk);
  endtask

  task automatic test_single_read();
    @(negedge clk);
    addr_a = {8'h00, 8'h00, 8'h10}; we_a = 3'b000; req_a = 3'b001;
    @(posedge clk); @(negedge clk);
    n_tests++;
    if ({gnt_a, ack_a, rd_a, wr_a, ao_a} !== {3'b001, 3'b000, 1'b1, 1'b0, 8'h10}) begin
      n_fail++; $display("FAIL read_strobe: got gnt=%b ack=%b rd=%b wr=%b addr=%h expected 001 000 1 0 10", gnt_a, ack_a, rd_a, wr_a, ao_a);
    end
    @(posedge clk); @(negedge clk);
    n_tests++;
    if ({ack_a, rdata_a, rd_a} !== {3'b001, 8'hA5, 1'b0}) begin
      n_fail++; $display("FAIL read_ack: got ack=%b rdata=%h rd=%b expected 001 a5 0", ack_a, rdata_a, rd_a);
    end
    req_a = 3'b000;
    @(posedge clk); @(negedge clk);
    n_tests++;
    if ({ack_a, gnt_a, rdata_a} !== {3'b000, 3'b000, 8'hA5}) begin
      n_fail++; $display("FAIL read_done: got ack=%b gnt=%b rdata=%h expected 000 000 a5", ack_a, gnt_a, rdata_a);
    end
    repeat (2) @(posedge clk);
  endtask

  task automatic test_write();
    logic [2:0] got;
    int cnt, bad;
    // Read first so rdata holds a known non-zero value before the write.
    @(negedge clk);
    addr_b = {8'h00, 8'h22, 8'h00}; we_b = 3'b000; req_b = 3'b010;
    got = 3'b000; cnt = 0; bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ack_b != 3'b000) begin got = ack_b; break; end
      if (rd_b) begin cnt++; if (ao_b !== 8'h22 || gnt_b !== 3'b010) bad++; end
      if (wr_b) bad++;
    end
    n_tests++;
    if (got !== 3'b010 || cnt != 4 || bad != 0) begin
      n_fail++; $display("FAIL read4: got ack=%b strobes=%0d bad=%0d expected 010 4 0", got, cnt, bad);
    end
    n_tests++;
    if (rdata_b !== 8'h3C) begin
      n_fail++; $display("FAIL read4_data: got %h expected 3c", rdata_b);
    end
    req_b = 3'b000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    addr_b = {8'h3F, 8'h00, 8'h00}; wdata_b = {8'h5A, 16'h0000}; we_b = 3'b100; req_b = 3'b100;
    got = 3'b000; cnt = 0; bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ack_b != 3'b000) begin got = ack_b; break; end
      if (wr_b) begin cnt++; if (ao_b !== 8'h3F || di_b !== 8'h5A || gnt_b !== 3'b100) bad++; end
      if (rd_b) bad++;
    end
    n_tests++;
    if (got !== 3'b100 || cnt != 4 || bad != 0) begin
      n_fail++; $display("FAIL write4: got ack=%b strobes=%0d bad=%0d expected 100 4 0", got, cnt, bad);
    end
    n_tests++;
    if (rdata_b !== 8'h3C || wr_b !== 1'b0) begin
      n_fail++; $display("FAIL write_rdata_hold: got rdata=%h wr=%b expected 3c 0", rdata_b, wr_b);
    end
    req_b = 3'b000; we_b = 3'b000;
    repeat (3) @(posedge clk);
  endtask

  task automatic test_contention();
    logic [2:0] exp_seq [9];
    logic [2:0] got;
`ifdef SRAM_ARB_CPU_PRIO_EN
    exp_seq = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b010, 3'b100, 3'b010};
`else
    exp_seq = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100, 3'b010, 3'b100, 3'b010};
`endif
    @(negedge clk); rst_n_a = 1'b0;
    @(posedge clk); #1; rst_n_a = 1'b1;
    @(negedge clk);
    we_a = 3'b000; req_a = 3'b111;
    for (int i = 0; i < 9; i++) begin
      got = 3'b000;
      for (int j = 0; j < 10; j++) begin
        @(negedge clk);
        if (ack_a != 3'b000) begin got = ack_a; break; end
      end
      n_tests++;
      if (got !== exp_seq[i]) begin
        n_fail++; $display("FAIL contention_%0d: got ack=%b expected %b", i, got, exp_seq[i]);
      end
      req_a = req_a & ~got;
      @(negedge clk);
      req_a = (i + 1 < 6) ? 3'b111 : (i + 1 < 9) ? 3'b110 : 3'b000;
    end
    req_a = 3'b000;
    repeat (3) @(posedge clk);
  endtask

  task automatic test_reset_mid();
    logic [2:0] got;
    int cnt, bad, seen;
    @(negedge clk);
    addr_b = {8'h00, 8'h00, 8'h10}; we_b = 3'b000; req_b = 3'b001;
    @(posedge clk); @(posedge clk); @(negedge clk);
    n_tests++;
    if (rd_b !== 1'b1) begin
      n_fail++; $display("FAIL mid_strobe2: got rd=%b expected 1", rd_b);
    end
    rst_n_b = 1'b0; req_b = 3'b000;
    #1;
    n_tests++;
    if ({rd_b, wr_b, gnt_b} !== 5'b00000) begin
      n_fail++; $display("FAIL mid_async_drop: got rd=%b wr=%b gnt=%b expected 0 0 000", rd_b, wr_b, gnt_b);
    end
    @(posedge clk); #1; rst_n_b = 1'b1;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (ack_b != 3'b000 || gnt_b != 3'b000) seen++;
    end
    n_tests++;
    if (seen != 0) begin
      n_fail++; $display("FAIL mid_no_ack: got %0d active cycles expected 0", seen);
    end
    @(negedge clk);
    addr_b = {8'h05, 16'h0000}; wdata_b = {8'h99, 16'h0000}; we_b = 3'b100; req_b = 3'b100;
    got = 3'b000; cnt = 0; bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ack_b != 3'b000) begin got = ack_b; break; end
      if (wr_b) begin cnt++; if (ao_b !== 8'h05 || di_b !== 8'h99) bad++; end
      if (rd_b) bad++;
    end
    n_tests++;
    if (got !== 3'b100 || cnt != 4 || bad != 0) begin
      n_fail++; $display("FAIL mid_new_req: got ack=%b strobes=%0d bad=%0d expected 100 4 0", got, cnt, bad);
    end
    req_b = 3'b000; we_b = 3'b000;
    repeat (3) @(posedge clk);
  endtask

  task automatic test_req_drop();
    int acks, others, post;
    @(negedge clk);
    addr_b = {8'h00, 8'h22, 8'h00}; we_b = 3'b000; req_b = 3'b010;
    @(posedge clk); @(negedge clk);
    n_tests++;
    if (gnt_b !== 3'b010) begin
      n_fail++; $display("FAIL drop_gnt: got %b expected 010", gnt_b);
    end
    @(posedge clk); #1; req_b = 3'b000;
    acks = 0; others = 0; post = 0;
    repeat (15) begin
      @(negedge clk);
      if (ack_b == 3'b010) acks++;
      else if (ack_b != 3'b000) others++;
      else if (acks > 0 && gnt_b != 3'b000) post++;
    end
    n_tests++;
    if (acks != 1 || others != 0 || post != 0) begin
      n_fail++; $display("FAIL drop_ack: got acks=%0d others=%0d regrants=%0d expected 1 0 0", acks, others, post);
    end
    n_tests++;
    if (rdata_b !== 8'h3C) begin
      n_fail++; $display("FAIL drop_rdata: got %h expected 3c", rdata_b);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5C;
    mem[8'h10] = 8'hA5;
    mem[8'h22] = 8'h3C;
    test_reset();
    test_single_read();
    test_write();
    test_contention();
    test_reset_mid();
    test_req_drop();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
